clkdiv_monitor: RTL and testbench

CLKDIV_MONITOR -- requirements
Module: clkdiv_monitor

---
 rtl/clkdiv_mon_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/clkdiv_monitor.sv | 117 +++++++++++
 tb/tb_clkdiv_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_mon_pkg.sv
// clkdiv_mon_pkg: shared state encoding and error-counter width for the divided-clock monitor.
package clkdiv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        FAULT
    } state_t;

    localparam int ERR_W = 8;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus delay flop giving a one-cycle rising-edge pulse.
//   clk      - sampling clock
//   rst_n    - asynchronous active-low reset
//   d        - asynchronous input
//   edge_det - one clk-cycle pulse, 2-3 cycles after a rising edge on d
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_det
);

    logic meta_q;
    logic sync_q;
    logic delay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            delay_q <= 1'b0;
        end else begin
            meta_q  <= d;
            sync_q  <= meta_q;
            delay_q <= sync_q;
        end
    end

    assign edge_det = sync_q & ~delay_q;

endmodule

// File: rtl/clkdiv_monitor.sv
// clkdiv_monitor: measures the period of a divided clock in source-clock cycles and tracks lock/fault.
//   hclkin       - source clock, all logic on its rising edge
//   resetn       - asynchronous active-low reset
//   divclk       - divided clock under test (asynchronous)
//   clr          - single-cycle pulse leaving FAULT
//   period       - last measured period
//   period_valid - one-cycle pulse per new measurement
//   locked       - high in LOCKED
//   fault        - high in FAULT
//   err_cnt      - saturating count of bad periods and timeouts
module clkdiv_monitor
    import clkdiv_mon_pkg::*;
#(
    parameter int DIV_RATIO  = 5,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             divclk,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] DIV_L  = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0] TOL_L  = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] LOCK_L = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TMO_L  = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gcnt;
    logic [CNT_W-1:0] diff;
    logic             edge_det;
    logic             clr_hit;
    logic             meas;
    logic             good;
    logic             tmo;
    logic             bad_evt;

    sync_edge_det u_sync (
        .clk     (hclkin),
        .rst_n   (resetn),
        .d       (divclk),
        .edge_det(edge_det)
    );

    // clr wins over a coincident edge in FAULT, so that edge is not measured
    assign clr_hit = (state == FAULT) && clr;
    assign meas    = edge_det && (state != IDLE) && !clr_hit;
    assign diff    = (cnt >= DIV_L) ? cnt - DIV_L : DIV_L - cnt;
    assign good    = diff <= TOL_L;
    // a timeout leaves ACQ/LOCKED immediately, so it is counted once per FAULT entry
    assign tmo     = ((state == ACQ) || (state == LOCKED)) && (cnt == TMO_L) && !edge_det;
    assign bad_evt = (meas && !good) || tmo;

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            gcnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            err_cnt      <= '0;
        end else begin
            period_valid <= meas;
            if (meas) period <= cnt;
            if (bad_evt && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            cnt <= clr_hit ? '0 : edge_det ? CNT_W'(1) : (cnt < TMO_L) ? cnt + 1'b1 : cnt;
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state <= ACQ;
                        gcnt  <= '0;
                    end
                end
                ACQ: begin
                    if (meas && good) begin
                        gcnt <= gcnt + 1'b1;
                        if (gcnt + 1'b1 == LOCK_L) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (meas) begin
                        gcnt <= '0;
                    end else if (tmo) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (bad_evt) begin
                        state  <= FAULT;
                        locked <= 1'b0;
                        fault  <= 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state <= IDLE;
                        gcnt  <= '0;
                        fault <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb_clkdiv_monitor: table-driven and scoreboard checks of clkdiv_monitor with default parameters.
module tb_clkdiv_monitor;

    logic        hclkin = 1'b0;
    logic        resetn;
    logic        divclk;
    logic        clr;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        fault;
    logic [7:0]  err_cnt;

    clkdiv_monitor #(
        .DIV_RATIO (5),
        .TOL       (0),
        .LOCK_COUNT(4),
        .TIMEOUT   (16),
        .CNT_W     (16)
    ) dut (
        .hclkin      (hclkin),
        .resetn      (resetn),
        .divclk      (divclk),
        .clr         (clr),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault),
        .err_cnt     (err_cnt)
    );

    always #5 hclkin = ~hclkin;

    typedef struct {
        int p;
        int n;
        bit do_clr;
        bit exp_locked;
        bit exp_fault;
        int exp_err;
    } row_t;

    row_t rows[19];
    int   sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   first  = 1'b1;
    bit   last_lvl = 1'b0;
    bit   in_fault = 1'b0;
    int   since  = 0;

    function automatic void chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endfunction

    always @(negedge hclkin) begin
        if (resetn && period_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_period_valid", int'(period), -1);
            end else begin
                chk("period", int'(period), sb.pop_front());
            end
        end
    end

    task automatic drive(input logic lvl);
        divclk = lvl;
        if (lvl && !last_lvl) begin
            if (!first) sb.push_back(since > 16 ? 16 : since);
            first = 1'b0;
            since = 0;
        end
        last_lvl = lvl;
        @(negedge hclkin);
        since++;
    endtask

    task automatic one_period(input int p, input int clr_at);
        for (int k = 0; k < p; k++) begin
            clr = (k == clr_at);
            drive(k < p / 2);
        end
        clr = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int j = 0; j < rows[i].n; j++)
                one_period(rows[i].p, (rows[i].do_clr && j == rows[i].n - 1) ? 3 : -1);
            if (rows[i].do_clr && in_fault) first = 1'b1;
            chk($sformatf("row%0d_locked", i), int'(locked), int'(rows[i].exp_locked));
            chk($sformatf("row%0d_fault", i), int'(fault), int'(rows[i].exp_fault));
            chk($sformatf("row%0d_err", i), int'(err_cnt), rows[i].exp_err);
            in_fault = rows[i].exp_fault;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmo_k;
        rows[0]  = '{5, 4,   0, 0, 0, 0};
        rows[1]  = '{5, 1,   0, 1, 0, 0};
        rows[2]  = '{5, 10,  1, 1, 0, 0};
        rows[3]  = '{7, 1,   0, 1, 0, 0};
        rows[4]  = '{5, 1,   0, 0, 1, 1};
        rows[5]  = '{5, 5,   0, 0, 1, 1};
        rows[6]  = '{5, 1,   1, 0, 0, 1};
        rows[7]  = '{5, 5,   0, 1, 0, 1};
        rows[8]  = '{6, 1,   0, 1, 0, 1};
        rows[9]  = '{5, 1,   0, 0, 1, 2};
        rows[10] = '{5, 1,   1, 0, 0, 2};
        rows[11] = '{5, 5,   0, 1, 0, 2};
        rows[12] = '{5, 5,   0, 1, 0, 3};
        rows[13] = '{5, 5,   0, 1, 0, 0};
        rows[14] = '{6, 1,   0, 1, 0, 0};
        rows[15] = '{6, 300, 0, 0, 1, 255};
        rows[16] = '{5, 1,   1, 0, 0, 255};
        rows[17] = '{6, 10,  0, 0, 0, 255};
        rows[18] = '{5, 1,   0, 0, 0, 255};

        resetn = 1'b0;
        divclk = 1'b0;
        clr    = 1'b0;
        repeat (3) @(negedge hclkin);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        resetn = 1'b1;
        @(negedge hclkin);

        run_rows(0, 11);

        // hold divclk high while locked: single timeout, then clr while still high
        tmo_k = 0;
        for (int k = 1; k <= 40; k++) begin
            clr = (k == 38);
            drive(1'b1);
            clr = 1'b0;
            if (k == 12) chk("hold_early_fault", int'(fault), 0);
            if (fault && tmo_k == 0) tmo_k = k;
            if (k == 30) chk("hold_err_once", int'(err_cnt), 3);
            if (k == 30) chk("hold_locked", int'(locked), 0);
        end
        chk("hold_timeout_in_window", int'(tmo_k >= 18 && tmo_k <= 20), 1);
        first = 1'b1;
        chk("hold_clr_fault", int'(fault), 0);
        chk("hold_clr_err", int'(err_cnt), 3);
        repeat (3) drive(1'b0);

        run_rows(12, 12);

        // asynchronous reset while locked with err_cnt = 3
        resetn = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_fault", int'(fault), 0);
        chk("arst_err", int'(err_cnt), 0);
        chk("arst_period", int'(period), 0);
        @(negedge hclkin);
        resetn = 1'b1;
        first = 1'b1;
        in_fault = 1'b0;
        sb.delete();

        run_rows(13, 18);

        repeat (10) drive(1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
